// File: rtl/dma_burst_engine.sv
// Bus-mastering DMA: copies LENGTH device words into Memory at BASE_ADDR in 4-word bursts.
// Optional build macro DMA_CYCLE_STEAL_EN releases the bus for one cycle between bursts.
module dma_burst_engine #(
    parameter logic [15:0] BASE_ADDR    = 16'h01F4,
    parameter int          LENGTH       = 12,
    parameter int          WRITE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd,
    input  logic        BG,
    input  logic [63:0] edata,
    output logic        BR,
    output logic        WRITE,
    output logic [15:0] addr,
    output logic [63:0] data,
    output logic [1:0]  offset,
    output logic        interrupt
);

    localparam int                BEAT_W     = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WRITE_CYCLES - 1);
    localparam logic [1:0]        LAST_BURST = 2'(LENGTH / 4 - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] XFER = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef DMA_CYCLE_STEAL_EN
    localparam logic [2:0] GAP  = 3'd4;
`endif

    logic [2:0]        state;
    logic [1:0]        burst;
    logic [BEAT_W-1:0] beat;
    logic              drive;

    // A lost grant restarts the current burst from beat 0; completed bursts are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            burst     <= '0;
            beat      <= '0;
            interrupt <= 1'b0;
        end else begin
            interrupt <= (state == DONE);
            case (state)
                IDLE: begin
                    if (cmd) begin
                        state <= REQ;
                        burst <= '0;
                        beat  <= '0;
                    end
                end
                REQ: begin
                    if (BG) state <= XFER;
                end
                XFER: begin
                    if (!BG) begin
                        state <= REQ;
                        beat  <= '0;
                    end else if (beat == LAST_BEAT) begin
                        beat <= '0;
                        if (burst == LAST_BURST) begin
                            state <= DONE;
                            burst <= '0;
                        end else begin
                            burst <= burst + 2'd1;
`ifdef DMA_CYCLE_STEAL_EN
                            state <= GAP;
`endif
                        end
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
`ifdef DMA_CYCLE_STEAL_EN
                GAP:     state <= REQ;
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The bus is only ever driven while granted and actively transferring.
    assign drive  = BG && (state == XFER);
    assign WRITE  = drive;
    assign BR     = (state == REQ) || (state == XFER);
    assign offset = burst;
    assign addr   = drive ? (BASE_ADDR + {12'b0, burst, 2'b00}) : 16'hzzzz;
    assign data   = drive ? edata : {64{1'bz}};

endmodule
